// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter over req & en with a per-owner hold limit.
// The winner is searched from the previous owner onwards, so rotation never idles while anyone is eligible.
module rr_arbiter #(
   parameter int N = 3,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] en,
   output logic [N-1:0] grant,
   output logic         grant_valid
);
   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [N-1:0] elig, grant_n;
   logic [IW-1:0] owner, owner_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [IW:0] pick;
   logic keep;
   // Returns {found, index} of the first eligible bit after o; o itself is tried last only when incl_self.
   function automatic logic [IW:0] search(input logic [N-1:0] e, input logic [IW-1:0] o, input logic incl_self);
      logic [IW:0] r;
      int p;
      r = '0;
      for (int k = N; k >= 1; k--) begin
         p = (int'(o) + k) % N;
         if (e[p[IW-1:0]] && (k != N || incl_self)) r = {1'b1, p[IW-1:0]};
      end
      return r;
   endfunction
   always_comb begin
      elig = req & en;
      keep = elig[owner] && (MAX_HOLD == 0 || hold_cnt < HW'(MAX_HOLD));
      pick = search(elig, owner, state == IDLE);
      state_n = state;
      grant_n = grant;
      owner_n = owner;
      hold_n = hold_cnt;
      if (state == BUSY && keep) begin
         hold_n = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
      end else if (pick[IW]) begin
         state_n = BUSY;
         owner_n = pick[IW-1:0];
         grant_n = {{(N-1){1'b0}}, 1'b1} << pick[IW-1:0];
         hold_n = HW'(1);
      end else if (state == BUSY && elig[owner]) begin
         hold_n = HW'(1);
      end else begin
         state_n = IDLE;
         grant_n = '0;
         hold_n = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         grant_valid <= 1'b0;
         owner <= IW'(N - 1);
         hold_cnt <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         grant_valid <= |grant_n;
         owner <= owner_n;
         hold_cnt <= hold_n;
      end
   end
   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_elig: assert property (@(posedge clk) disable iff (rst) (grant & ~$past(elig)) == '0);
   a_valid: assert property (@(posedge clk) disable iff (rst) grant_valid == |grant);
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a rotation-order reference model.
module tb_rr_arbiter;
   localparam int N = 3;
   localparam int MAXH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req = '1;
   logic [N-1:0] en = '1;
   logic [N-1:0] grant;
   logic grant_valid;
   int errors = 0;
   int checks = 0;
   int m_owner, m_hold, m_last, m_pick, m_c;
   logic [N-1:0] m_e;
   rr_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst), .req(req), .en(en), .grant(grant), .grant_valid(grant_valid)
   );
   always #5 clk = ~clk;
   function automatic logic [N-1:0] m_grant();
      return (m_owner < 0) ? '0 : N'(1) << m_owner;
   endfunction
   // Model: owner keeps while eligible and under the limit; otherwise the first eligible
   // requester in rotation order after the last owner wins (the old owner itself comes last).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1;
         m_hold = 0;
         m_last = N - 1;
      end else begin
         m_e = req & en;
         if (m_owner >= 0 && m_e[m_owner] && m_hold < MAXH) begin
            m_hold++;
         end else begin
            m_pick = -1;
            for (int k = 1; k <= N; k++) begin
               m_c = (m_last + k) % N;
               if (m_pick < 0 && m_e[m_c]) m_pick = m_c;
            end
            m_owner = m_pick;
            m_hold = (m_pick < 0) ? 0 : 1;
            if (m_pick >= 0) m_last = m_pick;
         end
      end
   end
   task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: grant=%b expected %b at %0t", nm, got, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         chk("model", grant, m_grant());
         checks++;
         if (grant_valid !== |m_grant()) begin
            errors++;
            $display("FAIL valid: grant_valid=%b expected %b at %0t", grant_valid, |m_grant(), $time);
         end
      end
   end
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      logic [N-1:0] e3;
      repeat (2) begin
         @(negedge clk);
         chk("reset", grant, 3'b000);
      end
      rst = 1'b0;
      req = 3'b000;
      repeat (2) begin
         @(negedge clk);
         chk("post_reset_idle", grant, 3'b000);
      end
      req = 3'b001;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("sole_regrant", grant, 3'b001);
      end
      do_reset();
      req = 3'b111;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         e3 = N'(1) << ((i / 4) % 3);
         chk("rotate_111", grant, e3);
      end
      do_reset();
      req = 3'b001;
      @(negedge clk);
      chk("owner0", grant, 3'b001);
      req = 3'b110;
      @(negedge clk);
      chk("switch_010", grant, 3'b010);
      req = 3'b000;
      @(negedge clk);
      chk("drop_idle", grant, 3'b000);
      do_reset();
      req = 3'b111;
      en = 3'b101;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         e3 = ((i / 4) % 2 == 0) ? 3'b001 : 3'b100;
         chk("en_mask", grant, e3);
      end
      do_reset();
      en = 3'b111;
      req = 3'b100;
      repeat (2) @(negedge clk);
      chk("owner2", grant, 3'b100);
      #2 rst = 1'b1;
      #1 chk("async_reset", grant, 3'b000);
      checks++;
      if (grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_valid: grant_valid=%b expected 0", grant_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      req = 3'b110;
      @(negedge clk);
      chk("ptr_reset", grant, 3'b010);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 49) == 0);
         req = N'($urandom);
         en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
